// File: rtl/dphy_lprx.sv
// D-PHY lane LP receiver: synchronises and deglitches Dp/Dn into LineState, tracks the
// LP-11 -> LP-01 -> LP-00 HS-entry handshake, sequences HS termination/receiver enables.
module dphy_lprx #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_CYCLES  = 2,
    parameter int unsigned LPX_MIN_TIME   = 4,
    parameter int unsigned HSTERM_EN_TIME = 2,
    parameter int unsigned HSSETTLE_TIME  = 8
) (
    input  logic       LPRX_CLK,
    input  logic       RxRst,
    input  logic       LPRX_EN,
    input  logic       Dp,
    input  logic       Dn,
    output logic [1:0] LineState,
    output logic       Stopstate,
    output logic       HSTERM_EN,
    output logic       HSRX_EN,
    output logic       RxActiveHS,
    output logic       ErrControl
);

    localparam int unsigned MaxLpTerm = (LPX_MIN_TIME > HSTERM_EN_TIME) ?
                                        LPX_MIN_TIME : HSTERM_EN_TIME;
    localparam int unsigned MaxTime   = (MaxLpTerm > HSSETTLE_TIME) ? MaxLpTerm : HSSETTLE_TIME;
    localparam int unsigned CntW      = $clog2(MaxTime) + 1;
    localparam int unsigned FiltW     = $clog2(FILTER_CYCLES) + 1;

    localparam logic [1:0] Lp00 = 2'b00;
    localparam logic [1:0] Lp01 = 2'b01;
    localparam logic [1:0] Lp10 = 2'b10;
    localparam logic [1:0] Lp11 = 2'b11;

    typedef enum logic [2:0] {
        StDisabled,
        StWaitStop,
        StStop,
        StHsRqst,
        StHsPrpr,
        StHsRx,
        StErr
    } state_e;

    // ------------------------------------------------------------------
    // Front end: synchroniser and persistence filter
    // ------------------------------------------------------------------
    logic [1:0]       sync_q [SYNC_STAGES];
    logic [1:0]       synced;
    logic [1:0]       prev_q;
    logic [1:0]       line_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic [FiltW-1:0] filt_cnt_d;
    logic             filt_load;

    always_ff @(posedge LPRX_CLK or posedge RxRst) begin
        if (RxRst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= Lp11;
            end
        end else begin
            sync_q[0] <= {Dp, Dn};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // A new candidate value restarts the run length at one.
    always_comb begin
        filt_cnt_d = '0;
        if (synced == line_q) begin
            filt_cnt_d = '0;
        end else if (synced != prev_q) begin
            filt_cnt_d = FiltW'(1);
        end else if (filt_cnt_q != '1) begin
            filt_cnt_d = filt_cnt_q + FiltW'(1);
        end else begin
            filt_cnt_d = filt_cnt_q;
        end
    end

    assign filt_load = (filt_cnt_d >= FiltW'(FILTER_CYCLES));

    always_ff @(posedge LPRX_CLK or posedge RxRst) begin
        if (RxRst) begin
            prev_q     <= Lp11;
            line_q     <= Lp11;
            filt_cnt_q <= '0;
        end else begin
            prev_q <= synced;
            if (filt_load) begin
                line_q     <= synced;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_d;
            end
        end
    end

    assign LineState = line_q;

    // ------------------------------------------------------------------
    // Line-state sequencer with registered outputs
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_inc;
    logic            stop_q;
    logic            term_q;
    logic            rx_q;
    logic            act_q;
    logic            err_q;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);

    always_ff @(posedge LPRX_CLK or posedge RxRst) begin
        if (RxRst) begin
            state_q <= StDisabled;
            cnt_q   <= '0;
            stop_q  <= 1'b0;
            term_q  <= 1'b0;
            rx_q    <= 1'b0;
            act_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            cnt_q <= cnt_inc;
            if (!LPRX_EN) begin
                state_q <= StDisabled;
                cnt_q   <= '0;
                stop_q  <= 1'b0;
                term_q  <= 1'b0;
                rx_q    <= 1'b0;
                act_q   <= 1'b0;
            end else begin
                case (state_q)
                    StDisabled: begin
                        state_q <= StWaitStop;
                        cnt_q   <= '0;
                    end
                    StWaitStop: begin
                        if (line_q == Lp11) begin
                            state_q <= StStop;
                            cnt_q   <= '0;
                            stop_q  <= 1'b1;
                        end
                    end
                    StStop: begin
                        if (line_q == Lp01) begin
                            state_q <= StHsRqst;
                            cnt_q   <= '0;
                            stop_q  <= 1'b0;
                        end else if (line_q != Lp11) begin
                            state_q <= StErr;
                            cnt_q   <= '0;
                            stop_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end
                    end
                    StHsRqst: begin
                        if (line_q == Lp00 && cnt_q >= CntW'(LPX_MIN_TIME)) begin
                            state_q <= StHsPrpr;
                            cnt_q   <= '0;
                        end else if (line_q == Lp11) begin
                            // Aborted request, not an error.
                            state_q <= StStop;
                            cnt_q   <= '0;
                            stop_q  <= 1'b1;
                        end else if (line_q == Lp00 || line_q == Lp10) begin
                            state_q <= StErr;
                            cnt_q   <= '0;
                            err_q   <= 1'b1;
                        end
                    end
                    StHsPrpr: begin
                        if (line_q == Lp11) begin
                            state_q <= StStop;
                            cnt_q   <= '0;
                            stop_q  <= 1'b1;
                            term_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (line_q != Lp00) begin
                            state_q <= StErr;
                            cnt_q   <= '0;
                            term_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else if (cnt_inc >= CntW'(HSSETTLE_TIME)) begin
                            state_q <= StHsRx;
                            cnt_q   <= '0;
                            term_q  <= 1'b1;
                            rx_q    <= 1'b1;
                            act_q   <= 1'b1;
                        end else if (cnt_inc >= CntW'(HSTERM_EN_TIME)) begin
                            term_q <= 1'b1;
                        end
                    end
                    StHsRx: begin
                        // Non-11 states are HS swing tripping the LP comparators.
                        if (line_q == Lp11) begin
                            state_q <= StStop;
                            cnt_q   <= '0;
                            stop_q  <= 1'b1;
                            term_q  <= 1'b0;
                            rx_q    <= 1'b0;
                            act_q   <= 1'b0;
                        end
                    end
                    StErr: begin
                        if (line_q == Lp11) begin
                            state_q <= StStop;
                            cnt_q   <= '0;
                            stop_q  <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StDisabled;
                        cnt_q   <= '0;
                        stop_q  <= 1'b0;
                        term_q  <= 1'b0;
                        rx_q    <= 1'b0;
                        act_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Stopstate  = stop_q;
    assign HSTERM_EN  = term_q;
    assign HSRX_EN    = rx_q;
    assign RxActiveHS = act_q;
    assign ErrControl = err_q;

endmodule

// File: tb/tb_dphy_lprx.sv
// Scoreboard bench for dphy_lprx: each stimulus step queues the output changes it should
// cause at a given cycle; every cycle the full output vector is compared to the expectation.
module tb_dphy_lprx;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dp;
    logic       dn;
    logic [1:0] line_state;
    logic       stopstate;
    logic       hsterm_en;
    logic       hsrx_en;
    logic       rx_active;
    logic       err_ctl;

    always #50 clk = ~clk;

    dphy_lprx dut (
        .LPRX_CLK   (clk),
        .RxRst      (rst),
        .LPRX_EN    (en),
        .Dp         (dp),
        .Dn         (dn),
        .LineState  (line_state),
        .Stopstate  (stopstate),
        .HSTERM_EN  (hsterm_en),
        .HSRX_EN    (hsrx_en),
        .RxActiveHS (rx_active),
        .ErrControl (err_ctl)
    );

    // Vector: {LineState[1:0], Stopstate, HSTERM_EN, HSRX_EN, RxActiveHS, ErrControl}
    localparam logic [6:0] MLs   = 7'b1100000;
    localparam logic [6:0] MStop = 7'b0010000;
    localparam logic [6:0] MTerm = 7'b0001000;
    localparam logic [6:0] MRx   = 7'b0000100;
    localparam logic [6:0] MAct  = 7'b0000010;
    localparam logic [6:0] MErr  = 7'b0000001;
    localparam logic [6:0] RstVal = 7'b1100000;

    typedef struct {
        int         cyc;
        logic [6:0] mask;
        logic [6:0] val;
    } ev_t;

    ev_t        sb[$];
    int         cyc      = 0;
    int         checks   = 0;
    int         failures = 0;
    logic [6:0] exp_out;
    logic [6:0] obs;

    assign obs = {line_state, stopstate, hsterm_en, hsrx_en, rx_active, err_ctl};

    task automatic push(input int ofs, input logic [6:0] m, input logic [6:0] v);
        ev_t e;
        e.cyc  = cyc + ofs;
        e.mask = m;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic push_ls(input int ofs, input logic [1:0] ls);
        push(ofs, MLs, {ls, 5'b00000});
    endtask

    task automatic push_err(input int ofs);
        push(ofs, MErr, MErr);
        push(ofs + 1, MErr, 7'b0);
    endtask

    task automatic drive(input logic [1:0] v);
        {dp, dn} = v;
    endtask

    // Advance to the next falling edge and retire the expectations due on this cycle.
    task automatic tick();
        ev_t keep[$];
        @(negedge clk);
        cyc++;
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) exp_out = (exp_out & ~sb[i].mask) | (sb[i].val & sb[i].mask);
            else keep.push_back(sb[i]);
        end
        sb = keep;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b0;
        drive(2'b11);
        exp_out = RstVal;
        #1;
        checks++;
        if (obs !== RstVal) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", obs, RstVal);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        push(2, MStop, MStop);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL reset_to_stop cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
        end
    endtask

    task automatic test_hs_burst();
        drive(2'b01);
        push_ls(4, 2'b01);
        push(5, MStop, 7'b0);
        for (int i = 1; i <= 34; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL hs_burst cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 6) begin
                drive(2'b00);
                push_ls(4, 2'b00);
                push(7, MTerm, MTerm);
                push(13, MRx | MAct, MRx | MAct);
            end
            if (i == 26) begin
                drive(2'b11);
                push_ls(4, 2'b11);
                push(5, MTerm | MRx | MAct | MStop, MStop);
            end
        end
    endtask

    task automatic test_rqst_abort();
        drive(2'b01);
        push_ls(4, 2'b01);
        push(5, MStop, 7'b0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL rqst_abort cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 2) begin
                drive(2'b11);
                push_ls(4, 2'b11);
                push(5, MStop, MStop);
            end
        end
    endtask

    task automatic test_short_rqst();
        drive(2'b01);
        push_ls(4, 2'b01);
        push(5, MStop, 7'b0);
        for (int i = 1; i <= 18; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL short_rqst cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 2) begin
                drive(2'b00);
                push_ls(4, 2'b00);
                push_err(5);
            end
            if (i == 10) begin
                drive(2'b11);
                push_ls(4, 2'b11);
                push(5, MStop, MStop);
            end
        end
    endtask

    task automatic test_glitch();
        drive(2'b01);
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL glitch cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 1) drive(2'b11);
        end
    endtask

    task automatic test_err_10();
        drive(2'b10);
        push_ls(4, 2'b10);
        push(5, MStop, 7'b0);
        push_err(5);
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL err_10 cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 8) begin
                drive(2'b11);
                push_ls(4, 2'b11);
                push(5, MStop, MStop);
            end
        end
    endtask

    task automatic test_prpr_abort();
        drive(2'b01);
        push_ls(4, 2'b01);
        push(5, MStop, 7'b0);
        for (int i = 1; i <= 22; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL prpr_abort cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 6) begin
                drive(2'b00);
                push_ls(4, 2'b00);
                push(7, MTerm, MTerm);
            end
            if (i == 12) begin
                drive(2'b11);
                push_ls(4, 2'b11);
                push(5, MTerm | MStop, MStop);
                push_err(5);
            end
        end
    endtask

    task automatic test_disable_hs();
        drive(2'b01);
        push_ls(4, 2'b01);
        push(5, MStop, 7'b0);
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL disable_hs cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 6) begin
                drive(2'b00);
                push_ls(4, 2'b00);
                push(7, MTerm, MTerm);
                push(13, MRx | MAct, MRx | MAct);
            end
            if (i == 22) begin
                en = 1'b0;
                push(1, MTerm | MRx | MAct, 7'b0);
            end
            if (i == 25) begin
                en = 1'b1;
                drive(2'b11);
                push_ls(4, 2'b11);
                push(5, MStop, MStop);
            end
        end
    endtask

    task automatic test_reset_mid_prpr();
        drive(2'b01);
        push_ls(4, 2'b01);
        push(5, MStop, 7'b0);
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL prpr_pre_reset cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
            if (i == 6) begin
                drive(2'b00);
                push_ls(4, 2'b00);
                push(7, MTerm, MTerm);
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== RstVal) begin
            failures++;
            $display("FAIL reset_mid_prpr got=%b want=%b", obs, RstVal);
        end
        exp_out = RstVal;
        sb.delete();
        drive(2'b11);
        tick();
        rst = 1'b0;
        push(2, MStop, MStop);
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++;
            if (obs !== exp_out) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%b want=%b", cyc, obs, exp_out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hs_burst();
        test_rqst_abort();
        test_short_rqst();
        test_glitch();
        test_err_10();
        test_prpr_abort();
        test_disable_hs();
        test_reset_mid_prpr();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
